sprite_rom_arbiter: RTL and testbench

Shares one single-port, synchronous-read sprite ROM (RGB565, 1-cycle read latency) among up to `NREQ` pixel-fetch requesters, such as dino, cactus, ground and score renderers. The arbiter grants one read per cycle using round-robin priority and drives the ROM address. It captures the returned pixel and steers a one-hot read-valid strobe back to the requester that owns it. The block sits between the per-sprite draw logic and the sprite ROM instance in the VGA pixel pipeline.

---
 rtl/sprite_rom_arbiter.sv | 95 +++++++++
 tb/tb_sprite_rom_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous-read sprite ROM among NREQ requesters.
// Grants one read per cycle and returns the pixel two cycles later with a one-hot owner strobe.
module sprite_rom_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 12,
  parameter int DW   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]   gnt,
  output logic [AW-1:0]     rom_address,
  input  logic [DW-1:0]     rom_data,
  output logic [DW-1:0]     rd_data,
  output logic [NREQ-1:0]   rd_valid,
  output logic              busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Handshake: a requester holds req[i] high with req_addr stable until it sees
  // gnt[i]=1 at a rising edge; that edge is the transfer, and the ROM never stalls.

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] tag1_q, tag1_d;
  logic [NREQ-1:0] rd_valid_q;
  logic [DW-1:0]   rd_data_q;

  logic [AW-1:0]   addr_a [NREQ];
  logic [PW:0]     sum;
  logic [PW-1:0]   cand;
  logic [PW-1:0]   win;
  logic            found;

  for (genvar g = 0; g < NREQ; g++) begin : g_addr
    assign addr_a[g] = req_addr[g*AW +: AW];
  end

  always_comb begin
    sum         = '0;
    cand        = '0;
    win         = '0;
    found       = 1'b0;
    gnt         = '0;
    rom_address = '0;
    ptr_d       = ptr_q;
    tag1_d      = '0;
    if (!reset) begin
      // Walk ptr, ptr+1, ... modulo NREQ; the first active request wins.
      for (int k = 0; k < NREQ; k++) begin
        sum = {1'b0, ptr_q} + (PW+1)'(k);
        if (sum >= (PW+1)'(NREQ)) begin
          sum = sum - (PW+1)'(NREQ);
        end
        cand = sum[PW-1:0];
        if (!found && req[cand]) begin
          found = 1'b1;
          win   = cand;
        end
      end
      if (found) begin
        gnt[win]    = 1'b1;
        rom_address = addr_a[win];
        if (win == PW'(NREQ-1)) begin
          ptr_d = '0;
        end else begin
          ptr_d = win + PW'(1);
        end
      end
      tag1_d = gnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q      <= '0;
      tag1_q     <= '0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
    end else begin
      ptr_q      <= ptr_d;
      tag1_q     <= tag1_d;
      rd_valid_q <= tag1_q;
      if (|tag1_q) begin
        rd_data_q <= rom_data;
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = (|tag1_q) | (|rd_valid_q);

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a behavioural ROM and a two-deep return model.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_sprite_rom_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 12;
  localparam int DW   = 16;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]   gnt;
  logic [AW-1:0]     rom_address;
  logic [DW-1:0]     rom_data;
  logic [DW-1:0]     rd_data;
  logic [NREQ-1:0]   rd_valid;
  logic              busy;

  logic [DW-1:0]     rom_mem [1 << AW];
  logic [AW-1:0]     addr_tb [NREQ];
  logic [NREQ+DW-1:0] exp_q[$];
  logic [DW-1:0]     last_data;

  int n_tests;
  int n_fail;

  sprite_rom_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_addr    (req_addr),
    .gnt         (gnt),
    .rom_address (rom_address),
    .rom_data    (rom_data),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .busy        (busy)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sprite ROM: one-cycle synchronous read
  always_ff @(posedge clk) begin
    rom_data <= rom_mem[rom_address];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input logic [NREQ-1:0] onehot);
    logic [AW-1:0] a;
    a = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (onehot[i]) a = addr_tb[i];
    end
    return a;
  endfunction

  // One clock cycle: apply inputs, check outputs, advance the return model.
  task automatic cycle(input logic rst, input logic [NREQ-1:0] r, input logic [NREQ-1:0] exp_gnt);
    logic [NREQ+DW-1:0] head;
    logic [NREQ-1:0]    head_tag;
    logic [NREQ-1:0]    next_tag;
    logic [AW-1:0]      exp_addr;
    reset = rst;
    req   = r;
    #1;
    exp_addr = addr_of(exp_gnt);
    check("gnt", 32'(gnt), 32'(exp_gnt));
    check("rom_address", 32'(rom_address), 32'(exp_addr));
    head     = exp_q.pop_front();
    head_tag = head[NREQ+DW-1:DW];
    if (head_tag != '0) last_data = head[DW-1:0];
    next_tag = exp_q[0][NREQ+DW-1:DW];
    check("rd_valid", 32'(rd_valid), 32'(head_tag));
    check("rd_data", 32'(rd_data), 32'(last_data));
    check("busy", 32'(busy), 32'((|head_tag) | (|next_tag)));
    exp_q.push_back({exp_gnt, rom_mem[exp_addr]});
    if (rst) begin
      exp_q.delete();
      exp_q.push_back('0);
      exp_q.push_back('0);
      last_data = '0;
    end
    @(negedge clk);
  endtask

  // Driver and directed vectors
  initial begin
    n_tests   = 0;
    n_fail    = 0;
    last_data = '0;
    reset     = 1'b1;
    req       = '0;
    addr_tb[0] = 12'h010;
    addr_tb[1] = 12'h123;
    addr_tb[2] = 12'h7FF;
    addr_tb[3] = 12'hABC;
    req_addr  = {addr_tb[3], addr_tb[2], addr_tb[1], addr_tb[0]};
    for (int a = 0; a < (1 << AW); a++) begin
      rom_mem[a] = 16'(a) * 16'd7 + 16'h1357;
    end
    rom_mem[12'h7FF] = 16'hF81F;
    exp_q.push_back('0);
    exp_q.push_back('0);
    @(negedge clk);

    // Reset held two cycles with everyone requesting
    cycle(1'b1, 4'b1111, 4'b0000);
    cycle(1'b1, 4'b1111, 4'b0000);
    // First cycle after release: ptr=0
    cycle(1'b0, 4'b1111, 4'b0001);
    cycle(1'b0, 4'b0000, 4'b0000);
    cycle(1'b0, 4'b0000, 4'b0000);
    cycle(1'b0, 4'b0000, 4'b0000);

    // Single read of 0x7FF by requester 2
    cycle(1'b0, 4'b0100, 4'b0100);
    cycle(1'b0, 4'b0000, 4'b0000);
    cycle(1'b0, 4'b0000, 4'b0000);
    check("pixel_7ff", 32'(rd_data), 32'h0000_F81F);
    cycle(1'b0, 4'b0000, 4'b0000);

    // Grant to index 3 wraps ptr to 0, then full contention
    cycle(1'b0, 4'b1000, 4'b1000);
    for (int c = 0; c < 8; c++) begin
      cycle(1'b0, 4'b1111, 4'(1 << (c % 4)));
    end
    cycle(1'b0, 4'b0000, 4'b0000);
    cycle(1'b0, 4'b0000, 4'b0000);
    cycle(1'b0, 4'b0000, 4'b0000);

    // Pointer skip: after granting 1, ptr=2 and req=0011 wraps to 0, then 1
    cycle(1'b0, 4'b0010, 4'b0010);
    cycle(1'b0, 4'b0011, 4'b0001);
    cycle(1'b0, 4'b0011, 4'b0010);
    cycle(1'b0, 4'b0000, 4'b0000);
    cycle(1'b0, 4'b0000, 4'b0000);
    cycle(1'b0, 4'b0000, 4'b0000);

    // Withdrawn request: 1 asks while 0 wins, then drops before its turn
    cycle(1'b0, 4'b0011, 4'b0001);
    cycle(1'b0, 4'b0001, 4'b0001);
    cycle(1'b0, 4'b0000, 4'b0000);
    cycle(1'b0, 4'b0000, 4'b0000);
    cycle(1'b0, 4'b0000, 4'b0000);

    // Reset mid-flight: grant 3, reset next cycle, no return afterwards
    cycle(1'b0, 4'b1100, 4'b0100);
    cycle(1'b0, 4'b1000, 4'b1000);
    cycle(1'b1, 4'b0000, 4'b0000);
    check("busy_after_reset", 32'(busy), 32'h0);
    cycle(1'b0, 4'b0000, 4'b0000);
    cycle(1'b0, 4'b1010, 4'b0010);
    cycle(1'b0, 4'b0000, 4'b0000);
    cycle(1'b0, 4'b0000, 4'b0000);
    cycle(1'b0, 4'b0000, 4'b0000);

    // Report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
